// File: rtl/dvbc_pkg.sv
// Shared DVB-C constellation codes and the mode-to-bits-per-symbol mapping.
package dvbc_pkg;

  localparam int DVBC_BYTE_W = 8;

  typedef enum logic [2:0] {
    MODE_QAM16  = 3'd0,
    MODE_QAM32  = 3'd1,
    MODE_QAM64  = 3'd2,
    MODE_QAM128 = 3'd3,
    MODE_QAM256 = 3'd4
  } qam_mode_e;

  // Reserved codes 5..7 fall back to 256-QAM.
  function automatic logic [3:0] qam_bits(input logic [2:0] mode);
    case (mode)
      MODE_QAM16:  qam_bits = 4'd4;
      MODE_QAM32:  qam_bits = 4'd5;
      MODE_QAM64:  qam_bits = 4'd6;
      MODE_QAM128: qam_bits = 4'd7;
      default:     qam_bits = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/dvbc_byte_to_symbol.sv
// Byte to MSB-first m-tuple converter; one register stage from byte to symbol.
// Input stalls once more than 8 bits are buffered; symbols hold while sym_ready_i is low.
module dvbc_byte_to_symbol
  import dvbc_pkg::*;
#(
  parameter int         SYM_WIDTH  = 8,
  parameter logic [2:0] RESET_MODE = 3'd2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [2:0]             mode_i,
  input  logic [DVBC_BYTE_W-1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [SYM_WIDTH-1:0]   sym_o,
  output logic                   sym_valid_o,
  input  logic                   sym_ready_i
);

  logic [15:0] r_acc;
  logic [4:0]  r_cnt;
  logic [2:0]  r_mode;

  logic [3:0]  w_m;
  logic        w_accept;
  logic        w_consume;
  logic [3:0]  w_s;
  logic [4:0]  w_base;
  logic [15:0] w_ins;
  logic [15:0] w_acc_nxt;
  logic [4:0]  w_cnt_nxt;
  logic [7:0]  w_sym8;

  assign w_m         = qam_bits(r_mode);
  assign ready_o     = (r_cnt <= 5'd8);
  assign sym_valid_o = (r_cnt >= {1'b0, w_m});
  assign w_accept    = valid_i && ready_o;
  assign w_consume   = sym_valid_o && sym_ready_i;
  assign w_s         = w_consume ? w_m : 4'd0;

  // New byte lands directly behind the bits that survive this cycle's shift.
  assign w_base    = r_cnt - {1'b0, w_s};
  assign w_ins     = w_accept ? ({data_i, 8'h00} >> w_base) : 16'h0000;
  assign w_acc_nxt = (r_acc << w_s) | w_ins;
  assign w_cnt_nxt = w_base + (w_accept ? 5'd8 : 5'd0);

  assign w_sym8 = r_acc[15:8] >> (4'd8 - w_m);

  always_comb begin
    sym_o      = '0;
    sym_o[7:0] = w_sym8;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_acc  <= 16'h0000;
      r_cnt  <= 5'd0;
      r_mode <= RESET_MODE;
    end else begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      // Mode only changes on an empty buffer so a group is never split across m values.
      if (w_cnt_nxt == 5'd0)
        r_mode <= mode_i;
    end
  end

endmodule

// File: tb/tb_dvbc_byte_to_symbol.sv
// Directed bench for dvbc_byte_to_symbol with an expected-symbol queue.
module tb_dvbc_byte_to_symbol;
  import dvbc_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [2:0] mode_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] sym_o;
  logic       sym_valid_o;
  logic       sym_ready_i;

  dvbc_byte_to_symbol #(.SYM_WIDTH(8), .RESET_MODE(3'd2)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .mode_i      (mode_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .sym_o       (sym_o),
    .sym_valid_o (sym_valid_o),
    .sym_ready_i (sym_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         n_pop  = 0;
  int         cyc    = 0;
  logic [7:0] exp_q[$];
  logic       chk_rdy    = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_sym   = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (rst_n_i === 1'b1) begin
      if (chk_rdy) check("ready_stream", 32'(ready_o), 32'h1);
      if (prev_stall) check("hold_sym", 32'(sym_o), 32'(prev_sym));
      if (sym_valid_o && sym_ready_i) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL extra_sym: observed %0h expected none", sym_o);
        end
        if (exp_q.size() != 0) begin
          check("sym", 32'(sym_o), 32'(exp_q.pop_front()));
          n_pop++;
        end
      end
      prev_stall <= sym_valid_o && !sym_ready_i;
      prev_sym   <= sym_o;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic send(input logic [7:0] b);
    int  n;
    logic acc;
    n       = 0;
    valid_i = 1'b1;
    data_i  = b;
    do begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end while (!acc && n < 100);
    valid_i = 1'b0;
    n_cmp++;
    assert (acc) else begin
      n_fail++;
      $error("FAIL send_timeout: byte %0h not accepted in %0d cycles", b, n);
    end
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || sym_valid_o) && k < 200) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    n_cmp++;
    assert (k < 200) else begin
      n_fail++;
      $error("FAIL %s_timeout: observed %0d symbols pending expected 0", tag, exp_q.size());
    end
    check({tag, "_idle_valid"}, 32'(sym_valid_o), 32'h0);
    check({tag, "_idle_ready"}, 32'(ready_o), 32'h1);
  endtask

  task automatic set_mode(input logic [2:0] m);
    mode_i = m;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int         c0;
    int         p0;
    logic [7:0] b;

    rst_n_i     = 1'b0;
    mode_i      = 3'd2;
    data_i      = 8'h00;
    valid_i     = 1'b0;
    sym_ready_i = 1'b1;
    #2;
    check("rst_ready", 32'(ready_o), 32'h1);
    check("rst_valid", 32'(sym_valid_o), 32'h0);
    check("rst_sym", 32'(sym_o), 32'h0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    // 64-QAM basic group
    set_mode(MODE_QAM64);
    exp_q.push_back(8'h2A); exp_q.push_back(8'h3C);
    exp_q.push_back(8'h37); exp_q.push_back(8'h2F);
    send(8'hAB);
    check("latency_valid", 32'(sym_valid_o), 32'h1);
    send(8'hCD);
    send(8'hEF);
    drain("qam64");

    // 32-QAM
    set_mode(MODE_QAM32);
    exp_q.push_back(8'h1F); exp_q.push_back(8'h1C); exp_q.push_back(8'h00); exp_q.push_back(8'h0F);
    exp_q.push_back(8'h1E); exp_q.push_back(8'h00); exp_q.push_back(8'h07); exp_q.push_back(8'h1F);
    send(8'hFF); send(8'h00); send(8'hFF); send(8'h00); send(8'hFF);
    drain("qam32");

    // 256-QAM streaming throughput
    set_mode(MODE_QAM256);
    c0 = cyc;
    p0 = n_pop;
    for (int i = 0; i < 100; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send(b);
      chk_rdy = 1'b1;
    end
    chk_rdy = 1'b0;
    check("stream_cycles", 32'(cyc - c0), 32'd100);
    @(negedge clk_i);
    #1;
    check("stream_pops", 32'(n_pop - p0), 32'd100);
    drain("qam256");

    // 16-QAM with downstream stall
    set_mode(MODE_QAM16);
    sym_ready_i = 1'b0;
    exp_q.push_back(8'h5); exp_q.push_back(8'hA);
    exp_q.push_back(8'h3); exp_q.push_back(8'hC);
    send(8'h5A);
    check("stall_sym_first", 32'(sym_o), 32'h5);
    send(8'h3C);
    check("stall_ready_low", 32'(ready_o), 32'h0);
    check("stall_valid", 32'(sym_valid_o), 32'h1);
    check("stall_sym", 32'(sym_o), 32'h5);
    repeat (5) @(posedge clk_i);
    #1;
    check("stall_sym_after", 32'(sym_o), 32'h5);
    sym_ready_i = 1'b1;
    drain("stall");

    // Mode change mid-group takes effect only at the group boundary
    set_mode(MODE_QAM64);
    exp_q.push_back(8'h2A); exp_q.push_back(8'h3C);
    exp_q.push_back(8'h37); exp_q.push_back(8'h2F);
    send(8'hAB);
    mode_i = MODE_QAM256;
    send(8'hCD);
    send(8'hEF);
    drain("modesw_group");
    exp_q.push_back(8'h81);
    send(8'h81);
    drain("modesw_256");

    // Reset with buffered bits
    set_mode(MODE_QAM16);
    sym_ready_i = 1'b0;
    exp_q.push_back(8'h1); exp_q.push_back(8'h2);
    exp_q.push_back(8'h3); exp_q.push_back(8'h4);
    send(8'h12);
    send(8'h34);
    sym_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    sym_ready_i = 1'b0;
    check("pre_rst_sym", 32'(sym_o), 32'h2);
    check("pre_rst_ready", 32'(ready_o), 32'h0);
    rst_n_i = 1'b0;
    #1;
    check("async_rst_valid", 32'(sym_valid_o), 32'h0);
    check("async_rst_ready", 32'(ready_o), 32'h1);
    check("async_rst_sym", 32'(sym_o), 32'h0);
    exp_q.delete();
    @(posedge clk_i);
    #1;
    rst_n_i     = 1'b1;
    sym_ready_i = 1'b1;
    set_mode(MODE_QAM16);
    exp_q.push_back(8'h3); exp_q.push_back(8'hC);
    send(8'h3C);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
